// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: captures decode operands/control, supports stall (hold) and
// flush (bubble), and counts inserted bubbles with a saturating counter.
module decode_execute_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [XLEN-1:0]  rd_data1_d,
  input  logic [XLEN-1:0]  rd_data2_d,
  input  logic [XLEN-1:0]  imm_ext_d,
  input  logic [RA_W-1:0]  rs1_d,
  input  logic [RA_W-1:0]  rs2_d,
  input  logic [RA_W-1:0]  rd_d,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic [1:0]       result_src_d,
  input  logic [2:0]       alu_ctrl_d,
  input  logic             alu_src_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             adder_src_d,
  input  logic             valid_d,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [XLEN-1:0]  rd_data1_e,
  output logic [XLEN-1:0]  rd_data2_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic [RA_W-1:0]  rs1_e,
  output logic [RA_W-1:0]  rs2_e,
  output logic [RA_W-1:0]  rd_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic [1:0]       result_src_e,
  output logic [2:0]       alu_ctrl_e,
  output logic             alu_src_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             adder_src_e,
  output logic             valid_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic [XLEN-1:0] imm_ext;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            adder_src;
    logic            valid;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Flush takes precedence over stall; the decode inputs are only sampled on a plain load,
  // so unknowns on them during a flush or stall never reach the register.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_e) begin
      ex_d  = '0;
      cnt_d = sat_inc(cnt_q);
    end else if (!stall_e) begin
      ex_d.pc         = pc_d;
      ex_d.pc_plus4   = pc_plus4_d;
      ex_d.rd_data1   = rd_data1_d;
      ex_d.rd_data2   = rd_data2_d;
      ex_d.imm_ext    = imm_ext_d;
      ex_d.rs1        = rs1_d;
      ex_d.rs2        = rs2_d;
      ex_d.rd         = rd_d;
      ex_d.reg_write  = reg_write_d;
      ex_d.mem_write  = mem_write_d;
      ex_d.result_src = result_src_d;
      ex_d.alu_ctrl   = alu_ctrl_d;
      ex_d.alu_src    = alu_src_d;
      ex_d.branch     = branch_d;
      ex_d.jump       = jump_d;
      ex_d.adder_src  = adder_src_d;
      ex_d.valid      = valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc_e         = ex_q.pc;
  assign pc_plus4_e   = ex_q.pc_plus4;
  assign rd_data1_e   = ex_q.rd_data1;
  assign rd_data2_e   = ex_q.rd_data2;
  assign imm_ext_e    = ex_q.imm_ext;
  assign rs1_e        = ex_q.rs1;
  assign rs2_e        = ex_q.rs2;
  assign rd_e         = ex_q.rd;
  assign reg_write_e  = ex_q.reg_write;
  assign mem_write_e  = ex_q.mem_write;
  assign result_src_e = ex_q.result_src;
  assign alu_ctrl_e   = ex_q.alu_ctrl;
  assign alu_src_e    = ex_q.alu_src;
  assign branch_e     = ex_q.branch;
  assign jump_e       = ex_q.jump;
  assign adder_src_e  = ex_q.adder_src;
  assign valid_e      = ex_q.valid;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg: a default instance plus a CNT_W=2 instance that
// shares its inputs, used to observe counter saturation.
module tb_decode_execute_reg;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic [31:0] pc_d, pc_plus4_d, rd_data1_d, rd_data2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d, adder_src_d, valid_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_ctrl_d;

  logic [31:0] pc_e, pc_plus4_e, rd_data1_e, rd_data2_e, imm_ext_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, adder_src_e, valid_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_ctrl_e;
  logic [15:0] bubble_cnt;

  logic [31:0] s_pc_e, s_pc_plus4_e, s_rd_data1_e, s_rd_data2_e, s_imm_ext_e;
  logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
  logic        s_reg_write_e, s_mem_write_e, s_alu_src_e, s_branch_e, s_jump_e;
  logic        s_adder_src_e, s_valid_e;
  logic [1:0]  s_result_src_e;
  logic [2:0]  s_alu_ctrl_e;
  logic [1:0]  s_bubble_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  decode_execute_reg dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd_data1_d(rd_data1_d), .rd_data2_d(rd_data2_d),
    .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .result_src_d(result_src_d),
    .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .adder_src_d(adder_src_d), .valid_d(valid_d),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd_data1_e(rd_data1_e), .rd_data2_e(rd_data2_e),
    .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
    .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
    .adder_src_e(adder_src_e), .valid_e(valid_e), .bubble_cnt(bubble_cnt)
  );

  decode_execute_reg #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd_data1_d(rd_data1_d), .rd_data2_d(rd_data2_d),
    .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .result_src_d(result_src_d),
    .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .adder_src_d(adder_src_d), .valid_d(valid_d),
    .pc_e(s_pc_e), .pc_plus4_e(s_pc_plus4_e), .rd_data1_e(s_rd_data1_e),
    .rd_data2_e(s_rd_data2_e), .imm_ext_e(s_imm_ext_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e),
    .rd_e(s_rd_e), .reg_write_e(s_reg_write_e), .mem_write_e(s_mem_write_e),
    .result_src_e(s_result_src_e), .alu_ctrl_e(s_alu_ctrl_e), .alu_src_e(s_alu_src_e),
    .branch_e(s_branch_e), .jump_e(s_jump_e), .adder_src_e(s_adder_src_e),
    .valid_e(s_valid_e), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    pc_d = $urandom; pc_plus4_d = $urandom; rd_data1_d = $urandom; rd_data2_d = $urandom;
    imm_ext_d = $urandom; rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
    reg_write_d = 1'b1; mem_write_d = 1'b1; result_src_d = 2'b11; alu_ctrl_d = 3'b111;
    alu_src_d = 1'b1; branch_d = 1'b1; jump_d = 1'b1; adder_src_d = 1'b1; valid_d = 1'b1;
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    rand_inputs();

    // Reset held two clocks with busy inputs
    tick();
    rand_inputs();
    tick();
    chk("rst_pc", pc_e, 32'h0);
    chk("rst_rd1", rd_data1_e, 32'h0);
    chk("rst_regwr", {31'b0, reg_write_e}, 32'h0);
    chk("rst_valid", {31'b0, valid_e}, 32'h0);
    chk("rst_cnt", {16'b0, bubble_cnt}, 32'h0);

    // Plain load with every field distinct
    reset = 1'b0;
    pc_d = 32'h0000_0040; pc_plus4_d = 32'h0000_0044; rd_data1_d = 32'h1234_5678;
    rd_data2_d = 32'h9ABC_DEF0; imm_ext_d = 32'hFFFF_FFF8; rs1_d = 5'd3; rs2_d = 5'd4;
    rd_d = 5'd7; reg_write_d = 1'b1; mem_write_d = 1'b0; result_src_d = 2'd2;
    alu_ctrl_d = 3'd5; alu_src_d = 1'b1; branch_d = 1'b0; jump_d = 1'b1;
    adder_src_d = 1'b1; valid_d = 1'b1;
    tick();
    chk("ld_pc", pc_e, 32'h40);
    chk("ld_pc4", pc_plus4_e, 32'h44);
    chk("ld_rd1", rd_data1_e, 32'h1234_5678);
    chk("ld_rd2", rd_data2_e, 32'h9ABC_DEF0);
    chk("ld_imm", imm_ext_e, 32'hFFFF_FFF8);
    chk("ld_regs", {17'b0, rs1_e, rs2_e, rd_e}, {17'b0, 5'd3, 5'd4, 5'd7});
    chk("ld_ctrl", {21'b0, reg_write_e, mem_write_e, result_src_e, alu_ctrl_e, alu_src_e,
                    branch_e, jump_e, adder_src_e},
                   {21'b0, 1'b1, 1'b0, 2'd2, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1});
    chk("ld_valid", {31'b0, valid_e}, 32'h1);
    chk("ld_cnt", {16'b0, bubble_cnt}, 32'h0);

    // Stall three clocks while decode PC advances
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_d = 32'h44 + 32'(4 * i);
      rd_data1_d = 32'hDEAD_0000 + 32'(i);
      tick();
      chk($sformatf("stall_pc%0d", i), pc_e, 32'h40);
      chk($sformatf("stall_rd1_%0d", i), rd_data1_e, 32'h1234_5678);
    end
    chk("stall_valid", {31'b0, valid_e}, 32'h1);
    chk("stall_cnt", {16'b0, bubble_cnt}, 32'h0);

    // Unknown decode inputs under stall must not leak
    pc_d = 'x; rd_data1_d = 'x; valid_d = 1'bx;
    tick();
    chk("stallx_pc", pc_e, 32'h40);
    chk("stallx_valid", {31'b0, valid_e}, 32'h1);

    // Flush with simultaneous stall inserts a bubble
    flush_e = 1'b1; stall_e = 1'b1; reg_write_d = 1'b1; rd_d = 5'd5;
    pc_d = 'x; valid_d = 1'b1;
    tick();
    chk("fl_regwr", {31'b0, reg_write_e}, 32'h0);
    chk("fl_rd", {27'b0, rd_e}, 32'h0);
    chk("fl_valid", {31'b0, valid_e}, 32'h0);
    chk("fl_pc", pc_e, 32'h0);
    chk("fl_rd1", rd_data1_e, 32'h0);
    chk("fl_adder", {31'b0, adder_src_e}, 32'h0);
    chk("fl_cnt", {16'b0, bubble_cnt}, 32'h1);

    // Resume loading; counter unchanged
    flush_e = 1'b0; stall_e = 1'b0; pc_d = 32'h80; valid_d = 1'b1;
    tick();
    chk("rl_pc", pc_e, 32'h80);
    chk("rl_rd", {27'b0, rd_e}, 32'h5);
    chk("rl_cnt", {16'b0, bubble_cnt}, 32'h1);

    // Five consecutive flushes: 2-bit counter saturates at 3
    reset = 1'b1;
    tick();
    reset = 1'b0; flush_e = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat_small%0d", i), {30'b0, s_bubble_cnt}, (i < 3) ? 32'(i) : 32'd3);
      chk($sformatf("sat_big%0d", i), {16'b0, bubble_cnt}, 32'(i));
    end

    // Reset coincident with flush: reset wins, counters cleared
    reset = 1'b1; flush_e = 1'b1; stall_e = 1'b1;
    tick();
    chk("rf_cnt", {16'b0, bubble_cnt}, 32'h0);
    chk("rf_small", {30'b0, s_bubble_cnt}, 32'h0);
    chk("rf_valid", {31'b0, valid_e}, 32'h0);
    chk("rf_pc", pc_e, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
